// File: rtl/fmul_seq.sv
// Byte-serial front end for an external FP32 multiplier: gathers two operands
// MSB-first, issues one multiply, waits with a bounded timer, then streams the result.
module fmul_seq #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic        mul_out_valid,
  input  logic [31:0] mul_out,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 8;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [CW-1:0] CNT_LAST = CW'(3);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [WW-1:0] a_q, a_d;
  logic [WW-1:0] b_q, b_d;
  logic [WW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          mul_start_q, mul_start_d;
  logic          busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      tmr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath updates; the byte counter wraps to 0 on each 4th transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_LOAD_A: begin
        if (in_valid && in_ready_q) begin
          a_d   = {a_q[WW-DW-1:0], in_data};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (in_valid && in_ready_q) begin
          b_d   = {b_q[WW-DW-1:0], in_data};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last permitted cycle still beats the timeout
        if (mul_out_valid) begin
          res_d   = mul_out;
          state_d = S_DRAIN;
        end else if (tmr_q == TMO_LAST) begin
          res_d   = QNAN;
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready && out_valid_q) begin
          res_d = {res_q[WW-DW-1:0], {DW{1'b0}}};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_LOAD_A;
        end
      end
      default: begin
        state_d = S_LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops present it in that state
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    mul_start_d = 1'b0;
    busy_d      = 1'b1;
    in_ready_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    out_valid_d = (state_d == S_DRAIN);
    mul_start_d = (state_d == S_ISSUE);
    busy_d      = !((state_d == S_LOAD_A) && (cnt_d == '0));
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q[WW-1:WW-DW];
  assign mul_start = mul_start_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Randomized scoreboard bench for fmul_seq with a behavioural multiplier model.
module tb_fmul_seq;

  localparam int unsigned TMO  = 20;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] mul_a, mul_b;
  logic        mul_start;
  logic        mul_out_valid;
  logic [31:0] mul_out = 32'h0;
  logic        busy, err;
  logic        mv_model = 1'b0;
  logic        mv_spur = 1'b0;

  assign mul_out_valid = mv_model | mv_spur;

  fmul_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_out_valid(mul_out_valid), .mul_out(mul_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          d;
    bit          spur;
  } op_t;

  op_t         ops_q[$];
  logic [7:0]  exp_q[$];
  int          lat_q[$];
  bit          errx_q[$];
  int          issue_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          err_model = 1'b0;
  bit          bp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer: 1010... when backpressure is enabled, always ready otherwise
  initial forever begin
    @(posedge clk); #1;
    out_ready = bp_en ? ~out_ready : 1'b1;
  end

  // Multiplier model: answers d cycles after the issue cycle (d=0 or d>TMO -> too late / never)
  initial forever begin
    @(negedge clk);
    if (rst_n && mul_start) begin
      if (ops_q.size() == 0) begin
        check("unexpected_mul_start", 32'd1, 32'd0);
      end else begin
        op_t op;
        int  k;
        op = ops_q.pop_front();
        check("mul_a_issue", mul_a, op.a);
        check("mul_b_issue", mul_b, op.b);
        issue_q.push_back(cyc);
        if (op.spur) begin
          mv_model = 1'b1;
          mul_out  = 32'hDEAD_BEEF;
        end
        k = 0;
        do begin
          @(posedge clk); #1;
          k++;
          if (k == 1) begin
            mv_model = 1'b0;
            check("mul_start_single", mul_start, 32'd0);
          end
          if (k == op.d) begin
            check("mul_a_hold", mul_a, op.a);
            check("mul_b_hold", mul_b, op.b);
            mv_model = 1'b1;
            mul_out  = op.res;
            @(posedge clk); #1;
            mv_model = 1'b0;
          end
        end while (k < op.d);
      end
    end
  end

  // Monitor: pops expected bytes on every output transfer
  initial begin
    bit         prev_ov = 1'b0;
    bit         chk_rdy = 1'b0;
    bit         hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    int         bidx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0; chk_rdy = 1'b0; hold = 1'b0; bidx = 0;
      end else begin
        if (chk_rdy) begin
          check("in_ready_after_drain", in_ready, 32'd1);
          chk_rdy = 1'b0;
        end
        if (hold) begin
          check("out_hold_valid", out_valid, 32'd1);
          check("out_hold_data", out_data, hold_data);
          hold = 1'b0;
        end
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0 || issue_q.size() == 0) begin
            check("unexpected_drain", 32'd1, 32'd0);
          end else begin
            int iss;
            iss = issue_q.pop_front();
            check("drain_latency", cyc - iss, lat_q.pop_front());
            check("err_on_drain", err, errx_q.pop_front());
          end
        end
        if (out_valid) check("busy_in_drain", busy, 32'd1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_byte", 32'd1, 32'd0);
          else check("out_byte", out_data, exp_q.pop_front());
          bidx++;
          if (bidx == 4) begin
            bidx = 0;
            chk_rdy = 1'b1;
          end
        end else if (out_valid) begin
          hold = 1'b1;
          hold_data = out_data;
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 4 * TMO + 100) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Queue an operation: expected bytes follow from the multiplier's answer time
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int d,
                         input logic [31:0] res, input bit spur, input bit gaps);
    op_t         op;
    logic [31:0] r;
    logic [63:0] word;
    op.a = a; op.b = b; op.res = res; op.d = d; op.spur = spur;
    ops_q.push_back(op);
    if (d >= 1 && d <= int'(TMO)) begin
      r = res;
      lat_q.push_back(d + 1);
    end else begin
      r = QNAN;
      err_model = 1'b1;
      lat_q.push_back(int'(TMO) + 1);
    end
    errx_q.push_back(err_model);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(r >> (24 - 8 * i)));
    word = {a, b};
    for (int i = 0; i < 8; i++) begin
      send_byte(word[63 - 8 * i -: 8], gaps);
      if (spur && i == 0) begin
        mv_spur = 1'b1;
        @(posedge clk); #1;
        mv_spur = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_mul_start", mul_start, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_err", err, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_op(32'h4000_0000, 32'h4000_0000, 3, 32'h4080_0000, 1'b0, 1'b0);
    wait_drain();
    @(negedge clk);
    check("busy_idle", busy, 32'd0);
    @(posedge clk); #1;

    bp_en = 1'b1;
    repeat (6) send_op($urandom, $urandom, int'($urandom_range(1, TMO)), $urandom, 1'b0, 1'b1);
    wait_drain();
    bp_en = 1'b0;

    send_op($urandom, $urandom, int'(TMO), 32'h1234_5678, 1'b0, 1'b0);
    send_op($urandom, $urandom, 1, 32'h3F80_0000, 1'b0, 1'b0);
    send_op($urandom, $urandom, 5, 32'hC0A0_0000, 1'b1, 1'b0);
    send_op($urandom, $urandom, 0, 32'h0, 1'b0, 1'b0);
    send_op($urandom, $urandom, 4, 32'h4110_0000, 1'b0, 1'b1);
    send_op($urandom, $urandom, int'(TMO) + 1, 32'h5555_AAAA, 1'b0, 1'b0);
    wait_drain();

    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    rst_n = 1'b0;
    err_model = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 32'd1);
    check("mid_rst_out_valid", out_valid, 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_err", err, 32'd0);
    check("mid_rst_mul_a", mul_a, 32'd0);
    check("mid_rst_mul_b", mul_b, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_op(32'h3F80_0000, 32'h4040_0000, 2, 32'h4040_0000, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
